// File: rtl/uart_rx_os8.sv
// uart_rx_os8: 8x-oversampled UART receiver fed by the baud generator's bclkx8.
// Validates the start bit, shifts in DATA_BITS data bits LSB first, then checks
// optional parity and the stop bit. Each word goes to the host over a valid/ack
// handshake, with frame, parity and overrun flags.
//
// Handshake: rx_valid rises when a word is loaded into rx_data and stays high
// until the host drives rx_ack. An rx_ack seen while rx_valid=1 clears rx_valid
// and all flags on the next cycle. If a new frame completes in that same cycle,
// the new frame is loaded instead. An rx_ack seen while rx_valid=0 is ignored.
// A frame that completes while rx_valid=1 and rx_ack=0 is dropped, and overrun
// is set.
module uart_rx_os8 #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 bclkx8,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic       ODD      = (PARITY_ODD != 0);
    localparam logic       HAS_PAR  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   bclkx8_q;
    logic                   tick;
    logic                   rx_m;
    logic                   rx_s;
    logic [2:0]             tick_cnt;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   pe_q;
    logic                   stop_q;
    logic                   done_q;
    logic                   sample_data;
    logic                   sample_par;
    logic                   sample_stop;

    // Each bclkx8 rising edge produces a single-cycle tick.
    assign tick = bclkx8 & ~bclkx8_q;
    assign busy = (state != S_IDLE);

    // Register bclkx8 for edge detection, and pass rx through a two-flop synchroniser (idle level 1).
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            bclkx8_q <= 1'b0;
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
        end else begin
            bclkx8_q <= bclkx8;
            rx_m     <= rx;
            rx_s     <= rx_m;
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic and sample strobes. The start bit is checked on its
    // 4th tick (mid-bit). After that, every 8th tick lands mid-bit again.
    always_comb begin
        state_next  = state;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                if (tick && tick_cnt == 3'd3) state_next = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && tick_cnt == 3'd7) begin
                    sample_data = 1'b1;
                    if (bit_cnt == LAST_BIT) state_next = HAS_PAR ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (tick && tick_cnt == 3'd7) begin
                    sample_par = 1'b1;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (tick && tick_cnt == 3'd7) begin
                    sample_stop = 1'b1;
                    state_next  = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Tick and bit counters. Both restart from zero on every state change.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            tick_cnt <= 3'd0;
            bit_cnt  <= 3'd0;
        end else if (state_next != state) begin
            tick_cnt <= 3'd0;
            bit_cnt  <= 3'd0;
        end else begin
            if (tick && state != S_IDLE && state != S_BREAK) tick_cnt <= tick_cnt + 3'd1;
            if (sample_data) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Frame datapath. Bits enter at the MSB so the final word is right-aligned.
    // The parity result is held until the frame completes.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            shreg  <= '0;
            pe_q   <= 1'b0;
            stop_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= sample_stop;
            if (state == S_IDLE && state_next == S_START) pe_q <= 1'b0;
            if (sample_data) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (sample_par)  pe_q  <= (((^shreg) ^ rx_s) != ODD);
            if (sample_stop) stop_q <= rx_s;
        end
    end

    // Host-side registers: load on completion (or flag overrun), clear on ack.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (done_q) begin
            if (!rx_valid || rx_ack) begin
                rx_data    <= shreg;
                frame_err  <= ~stop_q;
                parity_err <= pe_q;
                rx_valid   <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_os8.sv
// Bench for uart_rx_os8. Two receivers share one clock: dut_a has no parity,
// dut_p has even parity. A shortened bclkx8 period keeps the run short.
module tb_uart_rx_os8;

    localparam int BCLK_HALF = 8;               // bclkx8 period 16 sys_clk
    localparam int BIT       = 16 * BCLK_HALF;  // 128 sys_clk per bit
    localparam int BUDGET    = 12 * BIT;
    localparam int W         = 11;              // {sel, pe, fe, data}

    logic sys_clk = 1'b0;
    logic rst     = 1'b0;
    logic bclkx8  = 1'b0;
    logic rx_a    = 1'b1;
    logic rx_p    = 1'b1;
    logic ack_a   = 1'b0;
    logic ack_p   = 1'b0;

    logic [7:0] dat_a, dat_p;
    logic       valid_a, fe_a, pe_a, ov_a, busy_a;
    logic       valid_p, fe_p, pe_p, ov_p, busy_p;
    logic [4:0] st_a, st_p;

    int checks   = 0;
    int failures = 0;
    int bcnt     = 0;

    logic [W-1:0] exp_q[$];
    logic         vprev[2];

    typedef struct {
        bit           sel;
        logic [7:0]   data;
        logic         par;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[10];

    uart_rx_os8 #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .sys_clk(sys_clk), .rst(rst), .bclkx8(bclkx8), .rx(rx_a), .rx_ack(ack_a),
        .rx_data(dat_a), .rx_valid(valid_a), .frame_err(fe_a), .parity_err(pe_a),
        .overrun(ov_a), .busy(busy_a)
    );

    uart_rx_os8 #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .sys_clk(sys_clk), .rst(rst), .bclkx8(bclkx8), .rx(rx_p), .rx_ack(ack_p),
        .rx_data(dat_p), .rx_valid(valid_p), .frame_err(fe_p), .parity_err(pe_p),
        .overrun(ov_p), .busy(busy_p)
    );

    // status = {busy, overrun, parity_err, frame_err, rx_valid}
    assign st_a = {busy_a, ov_a, pe_a, fe_a, valid_a};
    assign st_p = {busy_p, ov_p, pe_p, fe_p, valid_p};

    // ---------------- clock / reset block ----------------
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (bcnt == BCLK_HALF - 1) begin
            bcnt   <= 0;
            bclkx8 <= ~bclkx8;
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [4:0] st(input bit sel);
        return sel ? st_p : st_a;
    endfunction

    function automatic logic [7:0] dat(input bit sel);
        return sel ? dat_p : dat_a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_p = v; else rx_a = v;
    endtask

    task automatic set_ack(input bit sel, input logic v);
        if (sel) ack_p = v; else ack_a = v;
    endtask

    // Drives start, 8 data bits (LSB first), optional parity, and stop.
    // When it returns, the line is left at the stop level.
    task automatic send_frame(input bit sel, input logic [7:0] d, input logic par, input logic stop);
        set_rx(sel, 1'b0);
        repeat (BIT) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            repeat (BIT) @(negedge sys_clk);
        end
        if (sel) begin
            set_rx(sel, par);
            repeat (BIT) @(negedge sys_clk);
        end
        set_rx(sel, stop);
        repeat (BIT) @(negedge sys_clk);
    endtask

    // Waits for the frame to start (busy rises) and for the stop sample (busy falls).
    // The cycle after busy falls is the completion cycle.
    task automatic wait_complete(input bit sel, input bit chk_lat, input bit ack_in_completion);
        int n;
        n = 0;
        while (!st(sel)[4] && n < BUDGET) begin @(negedge sys_clk); n++; end
        if (n >= BUDGET) check("busy_rise_timeout", 32'(n), 32'(BUDGET - 1));
        n = 0;
        while (st(sel)[4] && n < BUDGET) begin @(negedge sys_clk); n++; end
        if (n >= BUDGET) check("busy_fall_timeout", 32'(n), 32'(BUDGET - 1));
        if (ack_in_completion) begin
            set_ack(sel, 1'b1);
            @(negedge sys_clk);
            set_ack(sel, 1'b0);
        end else if (chk_lat) begin
            check("latency_pre", 32'(st(sel)[0]), 32'd0);
            @(negedge sys_clk);
            check("latency_valid", 32'(st(sel)[0]), 32'd1);
        end
    endtask

    task automatic do_ack(input bit sel);
        set_ack(sel, 1'b1);
        @(negedge sys_clk);
        set_ack(sel, 1'b0);
        check("ack_clear", 32'(st(sel)[3:0]), 32'd0);
    endtask

    task automatic run_frame(input bit sel, input logic [7:0] d, input logic par, input logic [W-1:0] exp);
        exp_q.push_back(exp);
        fork
            send_frame(sel, d, par, 1'b1);
            wait_complete(sel, 1'b1, 1'b0);
        join
        check("overrun_clear", 32'(st(sel)[3]), 32'd0);
        do_ack(sel);
    endtask

    // ---------------- scoreboard ----------------
    // Compares each newly loaded word (a rising edge of rx_valid) against the head of the queue.
    always @(negedge sys_clk) begin
        for (int s = 0; s < 2; s++) begin
            if (st(s[0])[0] && !vprev[s]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {21'd0, s[0], st(s[0])[2], st(s[0])[1], dat(s[0])}, 32'h7FF);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("word", {21'd0, s[0], st(s[0])[2], st(s[0])[1], dat(s[0])}, {21'd0, e});
                end
            end
            vprev[s] = st(s[0])[0];
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] r;
        logic       rp;
        logic [7:0] ab;
        bit         seen;

        vprev[0] = 1'b0;
        vprev[1] = 1'b0;

        r  = 8'($urandom_range(0, 255));
        rp = 1'($urandom_range(0, 1));
        vecs[0] = '{1'b0, 8'hA5, 1'b0, {3'b000, 8'hA5}};
        vecs[1] = '{1'b0, 8'h00, 1'b0, {3'b000, 8'h00}};
        vecs[2] = '{1'b0, 8'hFF, 1'b0, {3'b000, 8'hFF}};
        vecs[3] = '{1'b0, 8'h5A, 1'b0, {3'b000, 8'h5A}};
        vecs[4] = '{1'b0, r,     1'b0, {3'b000, r}};
        vecs[5] = '{1'b1, 8'h07, 1'b1, {3'b100, 8'h07}};
        vecs[6] = '{1'b1, 8'h07, 1'b0, {3'b110, 8'h07}};
        vecs[7] = '{1'b1, 8'h00, 1'b0, {3'b100, 8'h00}};
        vecs[8] = '{1'b1, 8'h80, 1'b0, {3'b110, 8'h80}};
        vecs[9] = '{1'b1, r,     rp,   {1'b1, ((^r) ^ rp), 1'b0, r}};

        // Reset values
        rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("reset_a", {19'd0, dat_a, st_a}, 32'd0);
        check("reset_p", {19'd0, dat_p, st_p}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Table-driven clean frames on both receivers
        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].exp);
            repeat (BIT / 2) @(negedge sys_clk);
        end

        // False start: line low for under half a bit
        seen = 1'b0;
        rx_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            if (busy_a) seen = 1'b1;
        end
        rx_a = 1'b1;
        repeat (200) @(negedge sys_clk);
        check("false_start_seen", 32'(seen), 32'd1);
        check("false_start_idle", 32'(st_a), 32'd0);

        // Frame error followed by a held-low break, then a clean frame
        exp_q.push_back({3'b001, 8'h3C});
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
        repeat (3 * BIT) @(negedge sys_clk);
        check("break_busy", 32'(busy_a), 32'd1);
        check("break_valid_fe", 32'(st_a[3:0]), 32'b0011);
        check("break_data", 32'(dat_a), 32'h3C);
        rx_a = 1'b1;
        repeat (6) @(negedge sys_clk);
        check("break_exit", 32'(busy_a), 32'd0);
        do_ack(1'b0);
        run_frame(1'b0, 8'h55, 1'b0, {3'b000, 8'h55});

        // Overrun: second frame dropped while the first is unacked
        exp_q.push_back({3'b000, 8'h11});
        fork send_frame(1'b0, 8'h11, 1'b0, 1'b1); wait_complete(1'b0, 1'b1, 1'b0); join
        fork send_frame(1'b0, 8'h22, 1'b0, 1'b1); wait_complete(1'b0, 1'b0, 1'b0); join
        check("ovr_data", 32'(dat_a), 32'h11);
        check("ovr_flags", 32'(st_a[3:0]), 32'b1001);
        do_ack(1'b0);

        // Ack in the completion cycle of the second frame: new word loaded, no overrun
        exp_q.push_back({3'b000, 8'h11});
        fork send_frame(1'b0, 8'h11, 1'b0, 1'b1); wait_complete(1'b0, 1'b1, 1'b0); join
        fork send_frame(1'b0, 8'h22, 1'b0, 1'b1); wait_complete(1'b0, 1'b0, 1'b1); join
        check("ackc_data", 32'(dat_a), 32'h22);
        check("ackc_flags", 32'(st_a[3:0]), 32'b0001);
        do_ack(1'b0);

        // Reset during data bit 4 of a frame
        ab = 8'hE7;
        rx_a = 1'b0;
        repeat (BIT) @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            rx_a = ab[i];
            repeat (BIT) @(negedge sys_clk);
        end
        rx_a = ab[4];
        repeat (BIT / 2) @(negedge sys_clk);
        check("pre_abort_data", 32'(dat_a), 32'h22);
        check("pre_abort_busy", 32'(busy_a), 32'd1);
        rst  = 1'b0;
        rx_a = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("rst_outputs", {19'd0, dat_a, st_a}, 32'd0);
        repeat (4) @(negedge sys_clk);
        rst = 1'b1;
        repeat (3 * BIT) @(negedge sys_clk);
        check("abort_no_output", {19'd0, dat_a, st_a}, 32'd0);
        run_frame(1'b0, 8'h81, 1'b0, {3'b000, 8'h81});

        repeat (10) @(negedge sys_clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_os8.md
Name: uart_rx_os8

Overview:
- UART receiver directly downstream of the baud rate generator.
- Consumes the generator's bclkx8 square wave (8x baud) as a sample-tick source.
- Deserialises an asynchronous rx line into parallel bytes, with start validation, optional parity and stop checking.
- Presents each received word to the host through a valid/ack handshake, with error and overrun flags.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8), LSB first.
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- bclkx8  in  1  8x-baud square wave from the baud generator; sys_clk-synchronous.
- rx  in  1  asynchronous serial input; idle high.
- rx_ack  in  1  host consumes the current word; 1-cycle pulse or level.
- rx_data  out  DATA_BITS  last accepted word.
- rx_valid  out  1  word available; held until acked.
- frame_err  out  1  stop bit of the word in rx_data sampled 0.
- parity_err  out  1  parity mismatch on the word in rx_data.
- overrun  out  1  a frame completed and was dropped while rx_valid=1.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0 at a sys_clk edge):
  - rx_data=0; rx_valid, frame_err, parity_err, overrun and busy all 0.
  - FSM to IDLE; tick/bit counters 0; edge-detect register 0; rx synchroniser flops 1.
  - Reset mid-frame abandons the frame with no output.
- Tick: tick = bclkx8 & ~bclkx8_q, where bclkx8_q is registered each cycle.
  - One tick per bclkx8 rising edge, i.e. 8 ticks per bit. Tick is 1 sys_clk wide.
- rx path: two-flop synchroniser giving rx_s; 2-cycle latency. All decisions use rx_s.
- tick_cnt is 3 bits and bit_cnt is 3 bits. Both clear on every state change.
- FSM states and transitions:
  - IDLE: rx_s==0 → START (tick not required).
  - START: on each tick, tick_cnt++. On the tick where tick_cnt==3 (mid start bit):
    - rx_s==0 → DATA.
    - rx_s==1 → IDLE (false start; no flags, no output).
  - DATA: on each tick, tick_cnt++ with 3-bit wrap. On the tick where tick_cnt==7, sample rx_s:
    - Shift into the MSB of shreg (LSB-first reception); bit_cnt++.
    - After DATA_BITS samples → PARITY if PARITY_EN, else STOP.
  - PARITY: on the 8th tick, sample the parity bit.
    - Error when (XOR of data bits ^ parity bit) != PARITY_ODD.
  - STOP: on the 8th tick, sample the stop bit, then complete the frame.
    - Stop bit 1 → IDLE.
    - Stop bit 0 → BREAK.
  - BREAK: wait for rx_s==1, then → IDLE. No new start is detected while the line is held low.
- Frame completion (the cycle after the stop-sample tick):
  - rx_valid==0, or rx_ack==1 in that cycle:
    - Load rx_data (shreg right-aligned), frame_err and parity_err; rx_valid=1.
    - overrun is unchanged.
  - rx_valid==1 and rx_ack==0:
    - Discard the new frame; rx_data and the error flags are untouched; set overrun=1.
  - Frames with frame_err or parity_err still assert rx_valid.
- Ack:
  - rx_ack while rx_valid=1 and no simultaneous completion: clears rx_valid, frame_err, parity_err and overrun next cycle.
  - rx_ack while rx_valid=0: no effect.
- Latency: rx_valid rises 1 sys_clk after the stop-bit sample tick. Total latency is 2 synchroniser cycles plus 1 sys_clk after the stop tick.
- Sampling point: nominally 4/8 into each bit after start detection, giving ±3/8-bit tolerance to edge-detect jitter.
- busy: combinational from state != IDLE (BREAK counts as busy).
- bclkx8 stopped: FSM holds in place; no timeout.

Test Plan:
- Bench setup: SYS_CLK_FREQ=100 MHz, sel_baud=3 (38400 baud, bclkx8 period 324 sys_clk, bit = 2592 sys_clk), DATA_BITS=8, PARITY_EN=0.
- Send 0xA5 with stop=1 → rx_data=0xA5, rx_valid=1 one cycle after the stop tick, frame_err=parity_err=overrun=0. rx_ack → rx_valid=0 next cycle.
- rx low for 1000 sys_clk (under half a bit), then high → FSM returns IDLE from START, rx_valid stays 0, no flags.
- Send 0x3C with stop=0, line held low 3 bit times then released → rx_data=0x3C, rx_valid=1, frame_err=1. FSM sits in BREAK (busy=1) until rx high, then IDLE. A subsequent 0x55 frame is received correctly after ack.
- PARITY_EN=1, PARITY_ODD=0:
  - Send 0x07 with parity bit 1 → parity_err=0.
  - Send 0x07 with parity bit 0 → parity_err=1, rx_data=0x07.
- Send 0x11 then 0x22 without ack → rx_data=0x11, overrun=1. Ack clears everything.
  - Repeat with rx_ack pulsed in the exact completion cycle of 0x22 → rx_data=0x22, rx_valid=1, overrun=0.
- Assert rst=0 during data bit 4 of a frame, release, send 0x81 → no output from the aborted frame; 0x81 received cleanly; all outputs 0 during reset.
